// File: rtl/sos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sos_pkg                                                      |
// | Description : Shared constants, FSM state type and width helper for the    |
// |               time-multiplexed cascade SOS IIR scheduler.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sos_pkg;

   // MAC cycles per biquad: b0, b1, b2, a1, a2
   localparam int N_TAP = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sos_ctrl_state_e;

   // Index width for n items, never narrower than one bit
   function automatic int sos_clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sos_mod_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sos_mod_cnt                                                  |
// | Description : Modulo-MOD up-counter with synchronous clear (priority) and  |
// |               a wrap strobe asserted on the enabled terminal-count cycle.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sos_mod_cnt #(
   parameter int WD  = 3,
   parameter int MOD = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [WD-1:0] cnt_o,
   output logic          wrap_o
);

   logic [WD-1:0] cnt_q;
   logic [WD-1:0] cnt_d;
   logic          at_top;

   assign at_top = (cnt_q == WD'(MOD - 1));
   assign wrap_o = en_i & at_top;
   assign cnt_o  = cnt_q;

   // Next count: clear wins, otherwise step and fold back to zero at MOD-1
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_top ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sos_cascade_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sos_cascade_ctrl                                             |
// | Description : Scheduler for a shared-MAC cascade of N_SEC biquads. Takes   |
// |               one sample, walks section x tap driving coefficient address, |
// |               MAC load/accumulate and delay-register enables, then holds   |
// |               the result valid until accepted. Counts samples dropped      |
// |               while busy (saturating).                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sos_cascade_ctrl
   import sos_pkg::*;
#(
   parameter  int N_SEC  = 4,
   parameter  int DROP_W = 16,
   localparam int SEC_W  = sos_clog2_min1(N_SEC),
   localparam int ADDR_W = sos_clog2_min1(N_SEC * N_TAP)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              sample_ld_o,
   output logic [SEC_W-1:0]  sec_idx_o,
   output logic [2:0]        tap_idx_o,
   output logic [ADDR_W-1:0] coef_addr_o,
   output logic              mac_en_o,
   output logic              mac_clr_o,
   output logic              state_we_o,
   output logic              state_clr_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              busy_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   sos_ctrl_state_e   state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic              state_clr_q;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              run;
   logic              tap_wrap;
   logic              last_step;
   logic [2:0]        tap_cnt;
   logic [SEC_W-1:0]  sec_cnt;

   assign run         = (state_q == RUN);
   // clear_i masks acceptance so a flush can never race a new sample
   assign in_ready_o  = (state_q == IDLE) & ~clear_i;
   assign sample_ld_o = in_valid_i & in_ready_o;

   // Tap counter advances every RUN cycle; its wrap steps the section counter
   sos_mod_cnt #(
      .WD  (3),
      .MOD (N_TAP)
   ) u_tap_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (run),
      .clr_i  (clear_i),
      .cnt_o  (tap_cnt),
      .wrap_o (tap_wrap)
   );

   // Section wrap coincides with the final tap of the final section, which
   // also returns both counters to zero for the next sample
   sos_mod_cnt #(
      .WD  (SEC_W),
      .MOD (N_SEC)
   ) u_sec_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (tap_wrap),
      .clr_i  (clear_i),
      .cnt_o  (sec_cnt),
      .wrap_o (last_step)
   );

   // Next-state, result-valid and drop-counter logic
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      drop_cnt_d  = drop_cnt_q;
      if (clear_i) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         drop_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sample_ld_o) state_d = RUN;
            end
            RUN: begin
               if (last_step) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end
            end
            DONE: begin
               if (out_valid_q && out_ready_i) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         endcase
         if (in_valid_i && !in_ready_o && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end
   end

   // FSM, registered result-valid, flush pulse and drop counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         state_clr_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         state_clr_q <= clear_i;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign sec_idx_o   = sec_cnt;
   assign tap_idx_o   = tap_cnt;
   // Constant multiply keeps the address path free of any divider
   assign coef_addr_o = ADDR_W'(sec_cnt * N_TAP) + ADDR_W'(tap_cnt);
   assign mac_en_o    = run;
   assign mac_clr_o   = run & (tap_cnt == 3'd0);
   assign state_we_o  = run & (tap_cnt == 3'(N_TAP - 1));
   assign state_clr_o = state_clr_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = (state_q != IDLE);
   assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sos_cascade_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sos_cascade_ctrl                                          |
// | Description : Scoreboard bench for sos_cascade_ctrl (N_SEC=4, DROP_W=4)    |
// |               plus a single-section instance.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sos_cascade_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, clear, in_valid, out_ready;
   logic in_ready, sample_ld, mac_en, mac_clr, state_we, state_clr, out_valid, busy;
   logic [1:0] sec_idx;
   logic [2:0] tap_idx;
   logic [4:0] coef_addr;
   logic [3:0] drop_cnt;

   logic clear1, in_valid1, out_ready1;
   logic in_ready1, sample_ld1, mac_en1, mac_clr1, state_we1, state_clr1, out_valid1, busy1;
   logic [0:0]  sec_idx1;
   logic [2:0]  tap_idx1;
   logic [2:0]  coef_addr1;
   logic [15:0] drop_cnt1;

   sos_cascade_ctrl #(.N_SEC(4), .DROP_W(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .sample_ld_o(sample_ld), .sec_idx_o(sec_idx),
      .tap_idx_o(tap_idx), .coef_addr_o(coef_addr), .mac_en_o(mac_en),
      .mac_clr_o(mac_clr), .state_we_o(state_we), .state_clr_o(state_clr),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy),
      .drop_cnt_o(drop_cnt)
   );

   sos_cascade_ctrl #(.N_SEC(1), .DROP_W(16)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1), .in_valid_i(in_valid1),
      .in_ready_o(in_ready1), .sample_ld_o(sample_ld1), .sec_idx_o(sec_idx1),
      .tap_idx_o(tap_idx1), .coef_addr_o(coef_addr1), .mac_en_o(mac_en1),
      .mac_clr_o(mac_clr1), .state_we_o(state_we1), .state_clr_o(state_clr1),
      .out_valid_o(out_valid1), .out_ready_i(out_ready1), .busy_o(busy1),
      .drop_cnt_o(drop_cnt1)
   );

   int cyc    = 0;
   int n_vec  = 0;
   int n_miss = 0;
   int addr_q[$];
   int ovt_q[$];
   bit ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Wait for the result of dut, sampling on falling edges, bounded
   task automatic wait_ov(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid !== 1'b1 && n < budget);
      if (out_valid !== 1'b1) chk("ov_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard: an accepted sample pushes its 20-step schedule and its result cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (sample_ld === 1'b1) begin
            for (int a = 0; a < 20; a++) addr_q.push_back(a);
            ovt_q.push_back(cyc + 21);
         end
         if (mac_en === 1'b1) begin
            if (addr_q.size() == 0) chk("extra_mac", 32'd1, 32'd0);
            else begin : pop_step
               int a;
               a = addr_q.pop_front();
               chk("run_step", 32'({sec_idx, tap_idx, coef_addr, mac_clr, state_we}),
                   32'({2'(a / 5), 3'(a % 5), 5'(a), a % 5 == 0, a % 5 == 4}));
            end
         end
         if (out_valid === 1'b1 && !ov_prev) begin
            if (ovt_q.size() == 0) chk("extra_out", 32'd1, 32'd0);
            else chk("out_latency", cyc, ovt_q.pop_front());
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int last, ea, n_acc;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_mac", 32'({mac_en, mac_clr, state_we, state_clr, sample_ld}), 32'd0);
      chk("rst_in_ready1", 32'(in_ready1), 32'd1);

      // Single sample, downstream always ready
      @(posedge clk); #1 in_valid = 1'b1;
      @(negedge clk); chk("s2_load", 32'(sample_ld), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(40);
      chk("s2_ready_in_done", 32'(in_ready), 32'd0);
      chk("s2_mac_in_done", 32'(mac_en), 32'd0);
      chk("s2_busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("s2_out_valid_gone", 32'(out_valid), 32'd0);
      chk("s2_ready_back", 32'(in_ready), 32'd1);

      // Stalled output, drops accumulate and saturate
      @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1;
      @(negedge clk); chk("s3_load", 32'(sample_ld), 32'd1);
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("s3_drop", 32'(drop_cnt), (k - 1 > 15) ? 32'd15 : 32'(k - 1));
      end
      wait_ov(40);
      for (int i = 0; i < 8; i++) begin
         chk("s3_hold_valid", 32'(out_valid), 32'd1);
         chk("s3_hold_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         if (i == 6) out_ready = 1'b1;
         if (i == 7) in_valid = 1'b0;
         else @(negedge clk);
      end
      @(negedge clk);
      chk("s3_ready_back", 32'(in_ready), 32'd1);
      chk("s3_valid_gone", 32'(out_valid), 32'd0);
      chk("s3_drop_sat", 32'(drop_cnt), 32'd15);

      // Flush at section 2 tap 3
      @(posedge clk); #1 in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (13) begin @(posedge clk); #1; end
      clear = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("s4_pos", 32'({sec_idx, tap_idx}), 32'({2'd2, 3'd3}));
      chk("s4_ready_clr", 32'(in_ready), 32'd0);
      chk("s4_load_clr", 32'(sample_ld), 32'd0);
      @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
      addr_q.delete(); ovt_q.delete();
      @(negedge clk);
      chk("s4_state_clr", 32'(state_clr), 32'd1);
      chk("s4_idle", 32'({busy, mac_en, out_valid}), 32'd0);
      chk("s4_ready", 32'(in_ready), 32'd1);
      chk("s4_drop_cleared", 32'(drop_cnt), 32'd0);
      chk("s4_counters", 32'({sec_idx, tap_idx}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("s4_state_clr_once", 32'(state_clr), 32'd0);
      @(posedge clk); #1 in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(40);
      @(negedge clk); chk("s4_ready_back", 32'(in_ready), 32'd1);

      // Asynchronous reset while holding a result
      @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(40);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_async_valid", 32'(out_valid), 32'd0);
      chk("s5_async_idle", 32'({busy, mac_en, state_clr}), 32'd0);
      chk("s5_async_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b1;
      @(negedge clk); chk("s5_load", 32'(sample_ld), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(40);
      @(negedge clk); chk("s5_ready_back", 32'(in_ready), 32'd1);

      // Single-section instance under continuous input
      @(posedge clk); #1 in_valid1 = 1'b1;
      last = -1; ea = 0; n_acc = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (sample_ld1 === 1'b1) begin
            if (last >= 0) chk("s6_gap", cyc - last, 32'd7);
            last = cyc; n_acc++; ea = 0;
         end
         if (mac_en1 === 1'b1) begin
            chk("s6_addr", 32'({sec_idx1, coef_addr1, mac_clr1, state_we1}),
                32'({1'b0, 3'(ea), ea == 0, ea == 4}));
            ea++;
         end
         if (out_valid1 === 1'b1 && last >= 0) chk("s6_latency", cyc - last, 32'd6);
      end
      chk("s6_accepts", n_acc, 32'd5);
      @(posedge clk); #1 in_valid1 = 1'b0;

      chk("sb_steps_left", addr_q.size(), 32'd0);
      chk("sb_results_left", ovt_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
